// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_defs: state, datapath select, ALU and opcode encodings shared by the multicycle control unit.
package ctrl_defs;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// alu_decoder: maps ALUOp plus funct fields to an ALU operation, flagging unsupported funct3 codes.
module alu_decoder
    import ctrl_defs::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] f3,
    input  logic       op5,
    input  logic       f7,
    output logic [2:0] alu_control,
    output logic       illegal
);
    always_comb begin
        illegal     = 1'b0;
        alu_control = alu_op == ALUOP_SUB ? ALU_SUB : ALU_ADD;
        if (alu_op == ALUOP_FUNCT) begin
            case (f3)
                3'b000:  alu_control = (op5 & f7) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the shared RV32I-subset datapath, with memory stall handshake and retire counter.
module multicycle_ctrl
    import ctrl_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic        f7,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memWrite,
    output logic        adrSrc,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        regWrite,
    output logic [1:0]  resultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  immSrc,
    output logic [2:0]  ALUControl,
    output logic        trap,
    output logic [31:0] instret
);
    state_t     state, state_nx;
    logic [1:0] alu_op;
    logic       illegal, retire;
    logic       req_c, mw_c, ir_c, pc_c, rw_c, trap_c;

    alu_decoder u_alu_decoder (
        .alu_op     (alu_op),
        .f3         (f3),
        .op5        (op[5]),
        .f7         (f7),
        .alu_control(ALUControl),
        .illegal    (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state   <= state_nx;
            instret <= instret + 32'(retire);
        end
    end

    always_comb begin
        state_nx  = state;
        req_c     = 1'b0;
        mw_c      = 1'b0;
        ir_c      = 1'b0;
        pc_c      = 1'b0;
        rw_c      = 1'b0;
        trap_c    = 1'b0;
        retire    = 1'b0;
        adrSrc    = 1'b0;
        resultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state)
            FETCH: begin
                req_c     = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURES;
                ir_c      = mem_ready;
                pc_c      = mem_ready;
                state_nx  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_IMM;
                state_nx = (op == OP_LOAD || op == OP_STORE) ? MEMADR :
                           op == OP_RTYPE  ? EXECR :
                           op == OP_ITYPE  ? EXECI :
                           op == OP_BRANCH ? BEQ :
                           op == OP_JAL    ? JAL : TRAP;
            end
            MEMADR: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                state_nx = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adrSrc   = 1'b1;
                req_c    = 1'b1;
                state_nx = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                resultSrc = RES_DATA;
                rw_c      = 1'b1;
                retire    = 1'b1;
                state_nx  = FETCH;
            end
            MEMWRITE: begin
                adrSrc   = 1'b1;
                req_c    = 1'b1;
                mw_c     = mem_ready;
                retire   = mem_ready;
                state_nx = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR, EXECI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = state == EXECI ? SRCB_IMM : SRCB_RS2;
                alu_op   = ALUOP_FUNCT;
                state_nx = illegal ? TRAP : ALUWB;
            end
            ALUWB: begin
                rw_c     = 1'b1;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            BEQ: begin
                ALUSrcA  = SRCA_RS1;
                alu_op   = ALUOP_SUB;
                pc_c     = zero;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_c     = 1'b1;
                state_nx = ALUWB;
            end
            TRAP:    trap_c = 1'b1;
            default: state_nx = FETCH;
        endcase
    end

    assign immSrc = op == OP_STORE  ? IMM_S :
                    op == OP_BRANCH ? IMM_B :
                    op == OP_JAL    ? IMM_J : IMM_I;

    // Enables are squashed the instant reset falls so no partial write escapes.
    assign mem_req  = req_c & rst_n;
    assign memWrite = mw_c & rst_n;
    assign irWrite  = ir_c & rst_n;
    assign pcWrite  = pc_c & rst_n;
    assign regWrite = rw_c & rst_n;
    assign trap     = trap_c & rst_n;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams checked cycle by cycle against a behavioural model.
module tb_multicycle_ctrl;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
    localparam int P_ER = 6, P_EI = 7, P_WB = 8, P_BEQ = 9, P_JAL = 10, P_TRAP = 11;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic f7 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic mem_req, memWrite, adrSrc, irWrite, pcWrite, regWrite, trap;
    logic [1:0] resultSrc, ALUSrcA, ALUSrcB, immSrc;
    logic [2:0] ALUControl;
    logic [31:0] instret;
    logic [17:0] obs;
    logic [31:0] n_ret = '0;
    int errors = 0, checks = 0;
    string names [12] = '{"fetch", "decode", "memadr", "memread", "memwb", "memwrite",
                          "execr", "execi", "aluwb", "beq", "jal", "trap"};

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memWrite(memWrite), .adrSrc(adrSrc),
        .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite), .resultSrc(resultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .immSrc(immSrc), .ALUControl(ALUControl),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, memWrite, adrSrc, irWrite, pcWrite, regWrite,
                  resultSrc, ALUSrcA, ALUSrcB, immSrc, ALUControl, trap};

    function automatic logic [2:0] alu_fn();
        if (f3 == 3'd0) return (op[5] && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    // Expected output bundle for one cycle of a given instruction step.
    function automatic logic [17:0] ev(int ph, logic rdy);
        logic req = 0, mw = 0, adr = 0, ir = 0, pc = 0, rw = 0, tr = 0;
        logic [1:0] res = 0, a = 0, b = 0, imm;
        logic [2:0] alu = 0;
        imm = op == SW ? 2'd1 : op == BR ? 2'd2 : op == JL ? 2'd3 : 2'd0;
        case (ph)
            P_F:   begin req = 1; b = 2; res = 2; ir = rdy; pc = rdy; end
            P_D:   begin a = 1; b = 1; end
            P_MA:  begin a = 2; b = 1; end
            P_MR:  begin adr = 1; req = 1; end
            P_MWB: begin res = 1; rw = 1; end
            P_MW:  begin adr = 1; req = 1; mw = rdy; end
            P_ER:  begin a = 2; alu = alu_fn(); end
            P_EI:  begin a = 2; b = 1; alu = alu_fn(); end
            P_WB:  rw = 1;
            P_BEQ: begin a = 2; alu = 3'b001; pc = zero; end
            P_JAL: begin a = 1; b = 2; pc = 1; end
            default: tr = 1;
        endcase
        return {req, mw, adr, ir, pc, rw, res, a, b, imm, alu, tr};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_vec(string tag, logic [17:0] exp, logic [17:0] m);
        checks++;
        assert ((obs & m) === (exp & m))
        else begin
            errors++;
            $error("FAIL %s outputs=%h expected=%h", tag, obs & m, exp & m);
        end
    endtask

    task automatic check_ret(string tag, logic [31:0] exp);
        checks++;
        assert (instret === exp)
        else begin
            errors++;
            $error("FAIL %s instret=%h expected=%h", tag, instret, exp);
        end
    endtask

    task automatic cyc(int ph, logic rdy, logic [17:0] m = '1);
        mem_ready = rdy;
        #1;
        check_vec(names[ph], ev(ph, rdy), m);
        @(negedge clk);
    endtask

    task automatic mem(int ph, int w);
        repeat (w) cyc(ph, 1'b0);
        cyc(ph, 1'b1);
    endtask

    // Reset vector: FETCH selects with every enable held low.
    task automatic reset_pulse(string tag);
        rst_n = 1'b0;
        #1;
        check_vec(tag, ev(P_F, 1'b0) & 18'h1FFFF, '1);
        check_ret(tag, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_ret = '0;
    endtask

    task automatic run(logic [6:0] o, logic [2:0] fn3, logic fn7, logic z, int wf, int wm);
        bit trapped = 0;
        op = o; f3 = fn3; f7 = fn7; zero = z;
        mem(P_F, wf);
        cyc(P_D, rbit());
        case (o)
            LW: begin cyc(P_MA, rbit()); mem(P_MR, wm); cyc(P_MWB, rbit()); n_ret++; end
            SW: begin cyc(P_MA, rbit()); mem(P_MW, wm); n_ret++; end
            RT, IT: begin
                if (fn3 inside {3'd0, 3'd2, 3'd6, 3'd7}) begin
                    cyc(o == RT ? P_ER : P_EI, rbit());
                    cyc(P_WB, rbit());
                    n_ret++;
                end else begin
                    cyc(o == RT ? P_ER : P_EI, rbit(), ~18'h0000E);
                    trapped = 1;
                end
            end
            BR: begin cyc(P_BEQ, rbit()); n_ret++; end
            JL: begin cyc(P_JAL, rbit()); cyc(P_WB, rbit()); n_ret++; end
            default: trapped = 1;
        endcase
        if (trapped) begin
            repeat (10) cyc(P_TRAP, rbit());
            check_ret("trap_instret", n_ret);
            reset_pulse("trap_reset");
        end else begin
            check_ret("instret", n_ret);
        end
    endtask

    initial begin
        logic [6:0] ops [7] = '{LW, SW, RT, IT, BR, JL, BAD};
        logic [2:0] good_f3 [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
        #1;
        check_vec("reset", ev(P_F, 1'b0) & 18'h1FFFF, '1);
        check_ret("reset", 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(LW, 3'd2, 1'b0, 1'b0, 0, 0);
        run(SW, 3'd2, 1'b0, 1'b0, 0, 2);
        run(RT, 3'd0, 1'b1, 1'b0, 0, 0);
        run(RT, 3'd0, 1'b0, 1'b0, 0, 0);
        run(RT, 3'd7, 1'b0, 1'b0, 1, 0);
        run(IT, 3'd0, 1'b1, 1'b0, 0, 0);
        run(IT, 3'd6, 1'b0, 1'b0, 0, 0);
        run(BR, 3'd0, 1'b0, 1'b1, 0, 0);
        run(BR, 3'd0, 1'b0, 1'b0, 2, 0);
        run(JL, 3'd0, 1'b0, 1'b0, 0, 0);
        run(BAD, 3'd0, 1'b0, 1'b0, 0, 0);
        run(RT, 3'd1, 1'b0, 1'b0, 0, 0);
        // Abort a load while it is writing back.
        op = LW; f3 = 3'd2; f7 = 1'b0; zero = 1'b0;
        mem(P_F, 0); cyc(P_D, 1'b1); cyc(P_MA, 1'b1); mem(P_MR, 1);
        mem_ready = 1'b1;
        #1;
        check_vec("memwb_before_reset", ev(P_MWB, 1'b1), '1);
        reset_pulse("memwb_reset");
        run(RT, 3'd2, 1'b0, 1'b0, 0, 0);
        // Counter wrap: preload all-ones, then retire one instruction.
        op = RT; f3 = 3'd6; f7 = 1'b0;
        mem(P_F, 0);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        n_ret = 32'hFFFF_FFFF;
        cyc(P_D, 1'b0); cyc(P_ER, 1'b0); cyc(P_WB, 1'b1);
        n_ret++;
        check_ret("wrap", n_ret);
        check_ret("wrap_zero", 32'd0);
        for (int i = 0; i < 60; i++) begin
            logic [6:0] o;
            logic [2:0] fn;
            o  = ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 5) == 0) ? 3'($urandom) : good_f3[$urandom_range(0, 3)];
            run(o, fn, rbit(), rbit(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that sequences the shared RV32I-subset datapath: one ALU, one register bank, one unified instruction/data memory, and the fetch/decode/execute registers around them. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write enable from `op`, `f3`, `f7` and `zero`, and stalls on a memory ready handshake. It replaces the single-cycle decoder feeding `dataPath` in the multicycle build.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instr[6:0] from the instruction register.
- f3  in  3  instr[14:12].
- f7  in  1  instr[30].
- zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completed this cycle's access.
- mem_req  out  1  memory access requested this cycle.
- memWrite  out  1  store strobe, qualified by mem_ready.
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irWrite  out  1  load instruction register and OldPC.
- pcWrite  out  1  load PC from the result bus.
- regWrite  out  1  register bank write enable.
- resultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- ALUSrcB  out  2  ALU B select: 00 = rs2 register, 01 = immExt, 10 = constant 4.
- immSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- trap  out  1  illegal-instruction halt.
- instret  out  32  retired-instruction counter.

## Operation
- States are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL and TRAP.
- FETCH:
  - Drives adrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, add, resultSrc=10.
  - With mem_ready=1: irWrite=1 and pcWrite=1, then go to DECODE.
  - Otherwise hold in FETCH with no writes.
- DECODE: drives ALUSrcA=01, ALUSrcB=01, add, so that ALUOut = OldPC + imm. Next state by op:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BEQ.
  - 1101111 → JAL.
  - any other op → TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD:
  - Drives adrSrc=1, mem_req=1, resultSrc=00.
  - Goes to MEMWB when mem_ready=1, else holds.
- MEMWB: resultSrc=01, regWrite=1. Retires, then FETCH.
- MEMWRITE:
  - Drives adrSrc=1, mem_req=1, memWrite=mem_ready, resultSrc=00.
  - When mem_ready=1: retires, then FETCH. Otherwise holds.
- EXECR / EXECI: ALUSrcA=10; ALUSrcB=00 for EXECR and 01 for EXECI; function decode. Next state ALUWB.
- ALUWB: resultSrc=00, regWrite=1. Retires, then FETCH.
- BEQ:
  - Drives ALUSrcA=10, ALUSrcB=00, sub, resultSrc=00, pcWrite=zero.
  - Retires, then FETCH.
- JAL:
  - Drives ALUSrcA=01, ALUSrcB=10, add, resultSrc=00, pcWrite=1.
  - Next state ALUWB.
- TRAP: trap=1 and every enable is 0. Only reset leaves TRAP.
- Function decode (EXECR/EXECI), selected by f3:
  - 000 → sub if op[5] & f7, else add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - any other f3 → TRAP in the next cycle instead of ALUWB.
- immSrc is driven in every state from op: S for 0100011, B for 1100011, J for 1101111, otherwise I.
- Every output not listed for a state is 0.
- instret increments by 1 in each retiring cycle and wraps from FFFF_FFFF to 0.

## Timing
- Reset:
  - State becomes FETCH and instret becomes 0.
  - While rst_n=0, all enables (mem_req, memWrite, irWrite, pcWrite, regWrite) and trap are forced to 0 combinationally.
- Outputs are Moore, decoded from the state register. Exceptions that also depend on inputs:
  - mem_ready gating of irWrite, pcWrite and memWrite.
  - zero gating of pcWrite in BEQ.
- Latency with zero-wait memory:
  - lw: 5 cycles.
  - sw, R-type, I-type, jal: 4 cycles.
  - beq: 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No enable pulses while waiting.
- mem_ready is ignored in every state with mem_req=0.
- Reset asserted mid-instruction aborts it; no partial write is issued after rst_n falls.

## Structure
- Shared package (`ctrl_defs`) holds:
  - state encodings;
  - ALUControl, immSrc, resultSrc, ALUSrcA and ALUSrcB codes;
  - opcode constants.
- One sub-module, `alu_decoder`: combinational, takes ALUOp (00 add, 01 sub, 10 funct) plus f3, op[5] and f7, and produces ALUControl and an illegal flag.
- The FSM, output decode and instret counter live in `multicycle_ctrl`.

## Test plan
- lw (op=0000011, f3=010), mem_ready=1 throughout:
  - state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB;
  - regWrite=1 only in cycle 5 with resultSrc=01;
  - instret 0→1.
- sw with mem_ready=0 for 2 cycles in MEMWRITE:
  - memWrite=0 during the wait;
  - a single memWrite=1 pulse on the ready cycle;
  - total 6 cycles.
- R-type sub (f3=000, f7=1) → ALUControl=001 in EXECR. Same encoding with f7=0 → 000. f3=111 → 010.
- beq:
  - zero=1 → pcWrite=1 in cycle 3.
  - zero=0 → pcWrite=0.
  - Both take 3 cycles, then FETCH.
- Illegal op 1111111, or R-type with f3=001:
  - enters TRAP with trap=1;
  - no enables for 10 cycles;
  - rst_n pulse returns to FETCH with instret=0.
- rst_n falls during MEMWB: regWrite drops immediately, then FETCH after release. Preload instret to FFFF_FFFF and retire one instruction: instret wraps to 0.
